operand_fetch_stage: RTL and testbench

//  Decode-to-execute operand stage. Uses two register read ports to read rs1/rs2 from the register file's Q bus.

---
 rtl/operand_fetch_stage.sv | 127 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Decode-to-execute operand stage. Two read ports pull rs1/rs2 from the
//   register file Q bus. Same-cycle writeback data is forwarded into each port.
//   An EX-stage producer that is still in flight stalls the stage. The operand
//   set is latched into a 1-entry valid/ready register that feeds execute.
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_flush                drop the held and incoming operand set
//   i_valid / o_ready      upstream handshake (rs1/rs2 addresses)
//   i_rs1_addr/i_rs2_addr  source addresses
//   i_qbus                 register file contents, [0:N_REGS-1]
//   i_wb_en/addr/data      writeback port, forwarded and used for hold refresh
//   i_haz_en/i_haz_addr    pending EX producer
//   o_valid / i_ready      downstream handshake
//   o_rs*_addr/o_rs*_data  held operand set

// Single read port: register 0 reads as zero, and writeback data takes
// priority over the Q bus.
module operand_read_port #(
   parameter int N_REGS = 32,
   parameter int XLEN   = 32,
   parameter int AW     = $clog2(N_REGS)
) (
   input  logic [AW-1:0]                addr,
   input  logic [0:N_REGS-1][XLEN-1:0]  qbus,
   input  logic                         wb_en,
   input  logic [AW-1:0]                wb_addr,
   input  logic [XLEN-1:0]              wb_data,
   output logic [XLEN-1:0]              data
);
   always_comb begin
      data = '0;
      if (addr == '0)
         data = '0;
      else if (wb_en && wb_addr == addr)
         data = wb_data;
      else
         data = qbus[addr];
   end
endmodule

module operand_fetch_stage #(
   parameter int N_REGS = 32,
   parameter int XLEN   = 32,
   parameter int AW     = $clog2(N_REGS)
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_flush,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [AW-1:0]                i_rs1_addr,
   input  logic [AW-1:0]                i_rs2_addr,
   input  logic [0:N_REGS-1][XLEN-1:0]  i_qbus,
   input  logic                         i_wb_en,
   input  logic [AW-1:0]                i_wb_addr,
   input  logic [XLEN-1:0]              i_wb_data,
   input  logic                         i_haz_en,
   input  logic [AW-1:0]                i_haz_addr,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [AW-1:0]                o_rs1_addr,
   output logic [AW-1:0]                o_rs2_addr,
   output logic [XLEN-1:0]              o_rs1_data,
   output logic [XLEN-1:0]              o_rs2_data
);
   localparam int NPORTS = 2;

   logic [NPORTS-1:0][AW-1:0]   addr_in;
   logic [NPORTS-1:0][XLEN-1:0] rd_data;
   logic [NPORTS-1:0][AW-1:0]   addr_q;
   logic [NPORTS-1:0][XLEN-1:0] data_q;
   logic                        valid_q;
   logic                        haz;
   logic                        accept;

   assign addr_in[0] = i_rs1_addr;
   assign addr_in[1] = i_rs2_addr;

   for (genvar g = 0; g < NPORTS; g++) begin : g_port
      operand_read_port #(.N_REGS(N_REGS), .XLEN(XLEN), .AW(AW)) u_rd (
         .addr    (addr_in[g]),
         .qbus    (i_qbus),
         .wb_en   (i_wb_en),
         .wb_addr (i_wb_addr),
         .wb_data (i_wb_data),
         .data    (rd_data[g])
      );
   end

   // A producer targeting x0 never creates a dependency.
   assign haz = i_haz_en && (i_haz_addr != '0) &&
                ((i_haz_addr == i_rs1_addr) || (i_haz_addr == i_rs2_addr));

   // The hazard gates o_ready regardless of i_valid, so a stalled upstream
   // sees a steady not-ready. The held set keeps draining, so no bubble is added.
   assign o_ready = !haz && (!valid_q || i_ready);
   assign accept  = i_valid && o_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (i_flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         addr_q  <= addr_in;
         data_q  <= rd_data;
      end else if (valid_q && i_ready) begin
         valid_q <= 1'b0;
      end else if (valid_q) begin
         // A held operand must not go stale. A writeback that lands while
         // execute is back-pressured refreshes the matching operand.
         for (int n = 0; n < NPORTS; n++)
            if (i_wb_en && i_wb_addr != '0 && i_wb_addr == addr_q[n])
               data_q[n] <= i_wb_data;
      end
   end

   assign o_valid    = valid_q;
   assign o_rs1_addr = addr_q[0];
   assign o_rs2_addr = addr_q[1];
   assign o_rs1_data = data_q[0];
   assign o_rs2_data = data_q[1];
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage. Inputs change 1ns after the rising
// edge. Outputs are checked before the next edge.
module tb_operand_fetch_stage;
   localparam int N_REGS = 32;
   localparam int XLEN   = 32;
   localparam int AW     = 5;

   logic                        i_clk = 1'b0;
   logic                        i_rst, i_flush, i_valid, i_ready;
   logic                        i_wb_en, i_haz_en;
   logic [AW-1:0]               i_rs1_addr, i_rs2_addr, i_wb_addr, i_haz_addr;
   logic [XLEN-1:0]             i_wb_data;
   logic [0:N_REGS-1][XLEN-1:0] i_qbus;
   logic                        o_ready, o_valid;
   logic [AW-1:0]               o_rs1_addr, o_rs2_addr;
   logic [XLEN-1:0]             o_rs1_data, o_rs2_data;

   int n_vec = 0;
   int n_bad = 0;

   always #5 i_clk = ~i_clk;

   operand_fetch_stage #(.N_REGS(N_REGS), .XLEN(XLEN), .AW(AW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
      .o_ready(o_ready), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
      .i_qbus(i_qbus), .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr),
      .i_wb_data(i_wb_data), .i_haz_en(i_haz_en), .i_haz_addr(i_haz_addr),
      .o_valid(o_valid), .i_ready(i_ready), .o_rs1_addr(o_rs1_addr),
      .o_rs2_addr(o_rs2_addr), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      for (int i = 0; i < N_REGS; i++) i_qbus[i] = 32'hA000_0000 | i;
      i_qbus[3] = 32'h0000_3333;
      i_qbus[5] = 32'h0000_1234;
      i_qbus[7] = 32'h0000_7777;
      i_rst = 1; i_flush = 0; i_valid = 0; i_ready = 0;
      i_wb_en = 0; i_wb_addr = 0; i_wb_data = 0;
      i_haz_en = 0; i_haz_addr = 0; i_rs1_addr = 0; i_rs2_addr = 0;

      // Reset
      tick(); tick();
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_rs1",   o_rs1_data, 32'd0);
      chk("rst_rs2",   o_rs2_data, 32'd0);
      chk("rst_addr",  32'({o_rs1_addr, o_rs2_addr}), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      i_rst = 0;

      // Basic read, with rs2 = x0
      i_rs1_addr = 5; i_rs2_addr = 0; i_valid = 1; i_ready = 1;
      tick();
      chk("rd_valid", 32'(o_valid), 32'd1);
      chk("rd_rs1",   o_rs1_data, 32'h1234);
      chk("rd_rs2",   o_rs2_data, 32'd0);
      chk("rd_addr1", 32'(o_rs1_addr), 32'd5);

      // Same-cycle writeback forwarding
      i_wb_en = 1; i_wb_addr = 5; i_wb_data = 32'hDEAD;
      tick();
      chk("fwd_rs1", o_rs1_data, 32'hDEAD);
      // A writeback to x0 is never forwarded
      i_rs1_addr = 3; i_rs2_addr = 0; i_wb_addr = 0; i_wb_data = 32'hFFFF;
      tick();
      chk("fwd_x0_rs2", o_rs2_data, 32'd0);
      chk("fwd_x0_rs1", o_rs1_data, 32'h3333);
      i_wb_en = 0;

      // Hold with refresh
      i_rs1_addr = 0; i_rs2_addr = 3;
      tick();
      chk("hold_acc", o_rs2_data, 32'h3333);
      i_ready = 0; i_rs1_addr = 1; i_rs2_addr = 2;  // must not be taken
      settle(); chk("hold1_ready", 32'(o_ready), 32'd0);
      tick();
      chk("hold1_valid", 32'(o_valid), 32'd1);
      chk("hold1_rs2",   o_rs2_data, 32'h3333);
      i_wb_en = 1; i_wb_addr = 3; i_wb_data = 32'hBEEF;
      settle(); chk("hold2_ready", 32'(o_ready), 32'd0);
      tick();
      i_wb_en = 0;
      chk("hold2_rs2",   o_rs2_data, 32'hBEEF);
      chk("hold2_rs1",   o_rs1_data, 32'd0);
      chk("hold2_valid", 32'(o_valid), 32'd1);
      settle(); chk("hold3_ready", 32'(o_ready), 32'd0);
      tick();
      chk("hold3_valid", 32'(o_valid), 32'd1);
      chk("hold3_addr2", 32'(o_rs2_addr), 32'd3);
      chk("hold3_rs2",   o_rs2_data, 32'hBEEF);
      i_ready = 1; i_valid = 0;
      settle(); chk("drain_ready", 32'(o_ready), 32'd1);
      tick();
      chk("drain_valid", 32'(o_valid), 32'd0);

      // Hazard stall
      i_haz_en = 1; i_haz_addr = 7; i_rs1_addr = 7; i_rs2_addr = 0; i_valid = 1;
      settle(); chk("haz_ready", 32'(o_ready), 32'd0);
      tick();
      chk("haz_noacc", 32'(o_valid), 32'd0);
      i_haz_en = 0;
      settle(); chk("haz_clr_ready", 32'(o_ready), 32'd1);
      tick();
      chk("haz_clr_valid", 32'(o_valid), 32'd1);
      chk("haz_clr_rs1",   o_rs1_data, 32'h7777);
      i_haz_en = 1; i_haz_addr = 0; i_rs1_addr = 0; i_rs2_addr = 3;
      settle(); chk("haz_x0_ready", 32'(o_ready), 32'd1);
      tick();
      chk("haz_x0_rs2", o_rs2_data, 32'h3333);
      i_haz_addr = 3; i_rs1_addr = 1; i_rs2_addr = 3;
      settle(); chk("haz_rs2_ready", 32'(o_ready), 32'd0);
      i_haz_en = 0; i_haz_addr = 0;

      // Flush beats accept, and flush during hold
      i_flush = 1; i_rs1_addr = 5; i_rs2_addr = 0;
      tick();
      chk("flush_acc", 32'(o_valid), 32'd0);
      i_flush = 0; i_ready = 0;
      tick();
      chk("flush_pre", 32'(o_valid), 32'd1);
      i_valid = 0; i_flush = 1;
      tick();
      chk("flush_hold", 32'(o_valid), 32'd0);
      i_flush = 0;

      // Back-to-back throughput
      i_ready = 1; i_valid = 1;
      begin
         logic [XLEN-1:0] e1 [1:4];
         logic [XLEN-1:0] e2 [1:4];
         e1[1] = 32'hA000_0001; e2[1] = 32'hA000_0002;
         e1[2] = 32'hA000_0002; e2[2] = 32'h0000_3333;
         e1[3] = 32'h0000_3333; e2[3] = 32'hA000_0004;
         e1[4] = 32'hA000_0004; e2[4] = 32'h0000_1234;
         for (int k = 1; k <= 4; k++) begin
            i_rs1_addr = AW'(k); i_rs2_addr = AW'(k + 1);
            settle(); chk($sformatf("b2b%0d_ready", k), 32'(o_ready), 32'd1);
            tick();
            chk($sformatf("b2b%0d_valid", k), 32'(o_valid), 32'd1);
            chk($sformatf("b2b%0d_addr1", k), 32'(o_rs1_addr), 32'(k));
            chk($sformatf("b2b%0d_rs1", k), o_rs1_data, e1[k]);
            chk($sformatf("b2b%0d_rs2", k), o_rs2_data, e2[k]);
         end
      end

      // Reset while stalled
      i_ready = 0; i_valid = 0;
      tick();
      chk("stall_valid", 32'(o_valid), 32'd1);
      i_rst = 1;
      tick();
      chk("rst_stall_valid", 32'(o_valid), 32'd0);
      chk("rst_stall_rs1",   o_rs1_data, 32'd0);
      i_rst = 0;
      tick();
      chk("rst_stall_after", 32'(o_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
